// File: rtl/down_counter_timer_if.sv
// rtl/down_counter_timer_if.sv - control/status bundle for the down-counter/timer
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             expired;

  modport master (
    output load, load_val, en, auto_reload,
    input  count, tc, busy, expired
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output count, tc, busy, expired
  );
endinterface

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter/timer with one-shot or auto-reload
// Optional prescaler enabled by defining DOWN_COUNTER_TIMER_PRESCALE_EN.
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             busy_q;
  logic             expired_q;
  logic             step_d;

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  always_comb begin
    step_d = (pre_q == PRE_MAX);
    pre_d  = pre_q;
    if (state_q == RUN && bus.en) begin
      pre_d = step_d ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.load) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE >= 2);
  assign step_d = 1'b1;
`endif

  // tc holds while a RUN cycle is frozen by en=0; otherwise it is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (bus.load) begin
      count_q   <= bus.load_val;
      reload_q  <= bus.load_val;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
      if (bus.load_val != '0) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            tc_q <= 1'b0;
            if (step_d) begin
              if (count_q == WIDTH'(1)) begin
                tc_q <= 1'b1;
                if (bus.auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  count_q   <= '0;
                  state_q   <= EXPIRED;
                  busy_q    <= 1'b0;
                  expired_q <= 1'b1;
                end
              end else begin
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
        end
        default: begin
          tc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;

endmodule
